// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and default timing constants for the CAN receive front end
package can_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        RX
    } state_e;

    localparam int CLKS_PER_BIT = 16;
    localparam int SAMPLE_POINT = 11;
    localparam int SJW          = 2;
    localparam int STUFF_LEN    = 5;
    localparam int IDLE_BITS    = 11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/can_bit_destuffer_if.sv
// rtl/can_bit_destuffer_if.sv - raw line in, destuffed bit stream and frame events out
interface can_bit_destuffer_if;

    logic rx_in;
    logic destuff_en;
    logic frame_rst;
    logic sof;
    logic bit_en;
    logic bit_val;
    logic stuff_err;
    logic bus_idle;

    modport master (
        input  rx_in, destuff_en,
        output frame_rst, sof, bit_en, bit_val, stuff_err, bus_idle
    );

    modport slave (
        output rx_in, destuff_en,
        input  frame_rst, sof, bit_en, bit_val, stuff_err, bus_idle
    );

endinterface

// File: rtl/can_bit_timer.sv
// rtl/can_bit_timer.sv - rx synchroniser, falling-edge detect, bit counter with hard/soft sync
module can_bit_timer
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = can_pkg::CLKS_PER_BIT,
    parameter int SAMPLE_POINT = can_pkg::SAMPLE_POINT,
    parameter int SJW          = can_pkg::SJW
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic hold_i,
    input  logic hard_sync_i,
    input  logic resync_en_i,
    output logic rx_s_o,
    output logic fall_o,
    output logic sample_o
);

    localparam int CW = clog2(CLKS_PER_BIT);

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          resynced_q, resynced_d;

    assign rx_s_o   = sync_q[1];
    assign fall_o   = rx_prev_q & ~sync_q[1];
    assign sample_o = (cnt_q == CW'(SAMPLE_POINT));

    always_comb begin
        int e;
        e          = int'(cnt_q);
        cnt_d      = (e == CLKS_PER_BIT - 1) ? '0 : cnt_q + 1'b1;
        resynced_d = (e == CLKS_PER_BIT - 1) ? 1'b0 : resynced_q;
        if (hold_i) begin
            cnt_d      = '0;
            resynced_d = 1'b0;
            if (hard_sync_i) begin
                cnt_d      = CW'(1);
                resynced_d = 1'b1;
            end
        end else if (resync_en_i && fall_o && !resynced_q && !sample_o) begin
            // Late edges pull the counter back, early edges push it forward, both by at most SJW.
            resynced_d = 1'b1;
            if (e != 0 && e < SAMPLE_POINT) begin
                cnt_d = CW'(e + 1 - ((e < SJW) ? e : SJW));
            end else if (e > SAMPLE_POINT) begin
                cnt_d = (CLKS_PER_BIT - e <= SJW) ? CW'(1) : CW'((e + 1 + SJW) % CLKS_PER_BIT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            cnt_q      <= '0;
            resynced_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_i};
            rx_prev_q  <= sync_q[1];
            cnt_q      <= cnt_d;
            resynced_q <= resynced_d;
        end
    end

endmodule

// File: rtl/can_bit_destuffer.sv
// rtl/can_bit_destuffer.sv - CAN rx front end: frame FSM, stuff-bit removal, bus idle tracking
module can_bit_destuffer
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = can_pkg::CLKS_PER_BIT,
    parameter int SAMPLE_POINT = can_pkg::SAMPLE_POINT,
    parameter int SJW          = can_pkg::SJW,
    parameter int STUFF_LEN    = can_pkg::STUFF_LEN,
    parameter int IDLE_BITS    = can_pkg::IDLE_BITS
) (
    input  logic                clk,
    input  logic                rst,
    can_bit_destuffer_if.master cb
);

    localparam int RW = clog2(STUFF_LEN + 1);
    localparam int IW = clog2(IDLE_BITS + 1);

    logic rx_s, fall, sample;

    state_e        state_q, state_d;
    logic          first_q, first_d;
    logic          run_val_q, run_val_d;
    logic [RW-1:0] run_len_q, run_len_d;
    logic [IW-1:0] rec_cnt_q, rec_cnt_d, rec_next;
    logic          eof;
    logic          frame_rst_q, frame_rst_d;
    logic          sof_q, sof_d;
    logic          bit_en_q, bit_en_d;
    logic          bit_val_q, bit_val_d;
    logic          stuff_err_q, stuff_err_d;
    logic          bus_idle_q, bus_idle_d;

    can_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_POINT(SAMPLE_POINT),
        .SJW         (SJW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (cb.rx_in),
        .hold_i     (state_q == IDLE),
        .hard_sync_i((state_q == IDLE) && fall),
        .resync_en_i(state_q == RX),
        .rx_s_o     (rx_s),
        .fall_o     (fall),
        .sample_o   (sample)
    );

    assign rec_next = rx_s ? rec_cnt_q + 1'b1 : '0;
    assign eof      = rx_s && (rec_cnt_q == IW'(IDLE_BITS - 1));

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        run_val_d   = run_val_q;
        run_len_d   = run_len_q;
        rec_cnt_d   = rec_cnt_q;
        frame_rst_d = 1'b0;
        sof_d       = 1'b0;
        bit_en_d    = 1'b0;
        bit_val_d   = bit_val_q;
        stuff_err_d = 1'b0;
        bus_idle_d  = bus_idle_q;
        case (state_q)
            WAIT_IDLE: begin
                if (sample) begin
                    rec_cnt_d = rec_next;
                    if (eof) begin
                        bus_idle_d = 1'b1;
                        rec_cnt_d  = '0;
                        state_d    = IDLE;
                    end
                end
            end
            IDLE: begin
                if (fall) begin
                    frame_rst_d = 1'b1;
                    bus_idle_d  = 1'b0;
                    first_d     = 1'b1;
                    rec_cnt_d   = '0;
                    state_d     = RX;
                end
            end
            RX: begin
                if (sample) begin
                    if (first_q) begin
                        // A recessive SOF sample is a glitch; the bus must re-qualify as idle.
                        first_d = 1'b0;
                        if (!rx_s) begin
                            sof_d     = 1'b1;
                            run_val_d = 1'b0;
                            run_len_d = RW'(1);
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end else if (cb.destuff_en && run_len_q == RW'(STUFF_LEN)) begin
                        if (rx_s == run_val_q) begin
                            stuff_err_d = 1'b1;
                            rec_cnt_d   = '0;
                            state_d     = WAIT_IDLE;
                        end else begin
                            run_val_d = rx_s;
                            run_len_d = RW'(1);
                            rec_cnt_d = rec_next;
                        end
                    end else begin
                        bit_en_d  = 1'b1;
                        bit_val_d = rx_s;
                        run_val_d = rx_s;
                        if (rx_s != run_val_q) begin
                            run_len_d = RW'(1);
                        end else if (run_len_q != RW'(STUFF_LEN)) begin
                            run_len_d = run_len_q + 1'b1;
                        end
                        rec_cnt_d = rec_next;
                        if (eof) begin
                            bus_idle_d = 1'b1;
                            rec_cnt_d  = '0;
                            state_d    = IDLE;
                        end
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            first_q     <= 1'b0;
            run_val_q   <= 1'b1;
            run_len_q   <= '0;
            rec_cnt_q   <= '0;
            frame_rst_q <= 1'b0;
            sof_q       <= 1'b0;
            bit_en_q    <= 1'b0;
            bit_val_q   <= 1'b1;
            stuff_err_q <= 1'b0;
            bus_idle_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            run_val_q   <= run_val_d;
            run_len_q   <= run_len_d;
            rec_cnt_q   <= rec_cnt_d;
            frame_rst_q <= frame_rst_d;
            sof_q       <= sof_d;
            bit_en_q    <= bit_en_d;
            bit_val_q   <= bit_val_d;
            stuff_err_q <= stuff_err_d;
            bus_idle_q  <= bus_idle_d;
        end
    end

    assign cb.frame_rst = frame_rst_q;
    assign cb.sof       = sof_q;
    assign cb.bit_en    = bit_en_q;
    assign cb.bit_val   = bit_val_q;
    assign cb.stuff_err = stuff_err_q;
    assign cb.bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// tb/tb_can_bit_destuffer.sv - random and directed frames against a transmitter-side stuffing model
module tb_can_bit_destuffer;
    import can_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_bit_destuffer_if cb();

    can_bit_destuffer dut (
        .clk(clk),
        .rst(rst),
        .cb (cb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Capture-side monitor: collects delivered bits and drives destuff_en like the capture stage.
    bit got_q[$];
    int n_sof, n_frst, n_serr, n_st;

    initial begin
        n_sof = 0; n_frst = 0; n_serr = 0; n_st = 0;
        cb.destuff_en = 1'b1;
        forever begin
            @(negedge clk);
            if (cb.bit_en) got_q.push_back(cb.bit_val);
            if (cb.sof) n_sof++;
            if (cb.frame_rst) n_frst++;
            if (cb.stuff_err) n_serr++;
            cb.destuff_en = (got_q.size() < n_st);
        end
    end

    function automatic logic [5:0] outs();
        return {cb.frame_rst, cb.sof, cb.bit_en, cb.bit_val, cb.stuff_err, cb.bus_idle};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit v, input int n);
        cb.rx_in = v;
        tick(n);
    endtask

    task automatic clear_mon(input int nst);
        got_q.delete();
        n_sof = 0; n_frst = 0; n_serr = 0;
        n_st = nst;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!cb.bus_idle && k < 2000) begin
            tick(1);
            k++;
        end
        chk(tag, cb.bus_idle, 1);
    endtask

    // Stuff the payload as a transmitter would, drive it, and compare what capture receives.
    task automatic run_frame(input bit pay[$], input int nst, input bit inj, input bit jit, input string tag);
        bit raw[$];
        bit stf[$];
        bit exp_q[$];
        bit rv;
        int rl, err_at, ones, cut, mism, jc, jn, dur;
        raw.push_back(1'b0); stf.push_back(1'b0);
        rv = 1'b0; rl = 1; err_at = -1;
        foreach (pay[i]) begin
            if (i < nst && rl == STUFF_LEN) begin
                raw.push_back(!rv); stf.push_back(1'b1);
                rv = !rv; rl = 1;
            end
            raw.push_back(pay[i]); stf.push_back(1'b0);
            rl = (pay[i] == rv) ? ((rl < STUFF_LEN) ? rl + 1 : rl) : 1;
            rv = pay[i];
        end
        if (inj) begin
            foreach (stf[i]) if (stf[i] && err_at < 0) err_at = i;
            if (err_at >= 0) raw[err_at] = !raw[err_at];
        end
        ones = 0;
        cut = raw.size() - 1;
        for (int i = 1; i < raw.size(); i++) begin
            if (i == err_at) begin
                cut = i;
                break;
            end
            if (!stf[i]) exp_q.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (ones == IDLE_BITS) begin
                cut = i;
                break;
            end
        end
        clear_mon(nst);
        jc = 0;
        for (int i = 0; i <= cut; i++) begin
            jn = (jit && i < cut) ? int'($urandom_range(0, 2)) - 1 : 0;
            dur = CLKS_PER_BIT + jn - jc;
            jc = jn;
            drive(raw[i], dur);
        end
        drive(1'b1, 13 * CLKS_PER_BIT);
        wait_idle({tag, "_idle"});
        chk({tag, "_nbits"}, got_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] != exp_q[i]) mism++;
        end
        chk({tag, "_bits"}, mism, 0);
        chk({tag, "_sof"}, n_sof, 1);
        chk({tag, "_frst"}, n_frst, 1);
        chk({tag, "_serr"}, n_serr, (err_at >= 0) ? 1 : 0);
    endtask

    task automatic resync_case(input int e, input int exp_cnt, input string tag);
        clear_mon(0);
        cb.rx_in = 1'b0;
        tick(2);
        chk({tag, "_frst_early"}, cb.frame_rst, 0);
        tick(1);
        chk({tag, "_frst"}, cb.frame_rst, 1);
        tick(11);
        chk({tag, "_sof"}, cb.sof, 1);
        tick(2);
        cb.rx_in = 1'b1;
        tick(16 + e);
        cb.rx_in = 1'b0;
        tick(3);
        chk({tag, "_cnt"}, dut.u_timer.cnt_q, exp_cnt);
        drive(1'b0, 13);
        drive(1'b1, 13 * CLKS_PER_BIT);
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        bit p[$];
        int k, nst, nb;
        bit b;
        cb.rx_in = 1'b1;
        tick(3);
        chk("reset_outs", outs(), 6'b000100);
        rst = 1'b0;
        clear_mon(0);
        k = 0;
        while (!cb.bus_idle && k < 400) begin
            tick(1);
            k++;
        end
        chk("idle_latency", k, SAMPLE_POINT + 1 + (IDLE_BITS - 1) * CLKS_PER_BIT);
        chk("idle_no_strobes", got_q.size() + n_sof + n_frst + n_serr, 0);

        resync_case(1, 1, "late1");
        resync_case(4, 3, "late4");
        resync_case(15, 1, "early15");

        p.delete();
        repeat (4) p.push_back(1'b0);
        repeat (12) p.push_back(1'b1);
        run_frame(p, 5, 1'b0, 1'b0, "stuff_ok");
        run_frame(p, 5, 1'b1, 1'b0, "stuff_err");

        p.delete();
        repeat (6) p.push_back(1'b1);
        p.push_back(1'b0);
        repeat (11) p.push_back(1'b1);
        run_frame(p, 0, 1'b0, 1'b0, "nostuff");

        for (int f = 0; f < 24; f++) begin
            p.delete();
            nst = $urandom_range(1, 40);
            nb = nst + $urandom_range(0, 6);
            b = 1'($urandom_range(0, 1));
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) b = !b;
                p.push_back(b);
            end
            repeat (IDLE_BITS) p.push_back(1'b1);
            drive(1'b1, $urandom_range(0, 40));
            run_frame(p, nst, $urandom_range(0, 2) == 0, 1'b1, $sformatf("rnd%0d", f));
        end

        clear_mon(0);
        drive(1'b0, CLKS_PER_BIT);
        drive(1'b1, CLKS_PER_BIT);
        drive(1'b0, 8);
        nb = got_q.size();
        rst = 1'b1;
        tick(1);
        chk("midframe_rst_outs", outs(), 6'b000100);
        tick(2);
        cb.rx_in = 1'b1;
        rst = 1'b0;
        tick(CLKS_PER_BIT);
        chk("midframe_rst_nobits", got_q.size(), nb);
        wait_idle("post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
